// File: rtl/sequential_alu_if.sv
// Request/result channel of sequential_alu.
// master: the requester/consumer side; slave: the ALU itself.
interface sequential_alu_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [2:0]       i_instruction;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] out;
    logic             o_valid;
    logic             i_ready;
    logic             o_carry;
    logic             o_zero;
    logic             o_overflow;
    logic             o_err;

    modport master (
        output i_a, i_b, i_instruction, i_valid, i_ready,
        input  o_ready, out, o_valid, o_carry, o_zero, o_overflow, o_err
    );

    modport slave (
        input  i_a, i_b, i_instruction, i_valid, i_ready,
        output o_ready, out, o_valid, o_carry, o_zero, o_overflow, o_err
    );
endinterface

// File: rtl/sequential_alu.sv
// sequential_alu: one request at a time, registered result and flags held
// until the consumer takes them. Logic ops, ADD and SUB finish on the accept
// edge; MUL (built only when SEQUENTIAL_ALU_MUL_EN is defined) runs a
// shift-add loop, one multiplier bit per cycle for WIDTH cycles. Without the
// macro, opcode 110 behaves exactly like the illegal opcode 111.
module sequential_alu #(
    parameter int WIDTH = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    sequential_alu_if.slave bus
);
    localparam logic [2:0] OP_OR   = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_NOR  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;

`ifdef SEQUENTIAL_ALU_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam int         CNT_W  = $clog2(WIDTH);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_carry;
    logic             w_alu_ovf;
    logic             w_alu_err;
    logic             w_load;
    logic [WIDTH-1:0] w_load_out;
    logic             w_load_carry;
    logic             w_load_zero;
    logic             w_load_ovf;
    logic             w_load_err;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;
    logic             r_zero;
    logic             r_overflow;
    logic             r_err;

    // Only IDLE takes requests; the handshake edge out of DONE never accepts.
    assign w_accept = bus.i_valid && (r_state == S_IDLE);

    // One extra bit catches the ADD carry-out and the SUB borrow.
    assign w_sum  = {1'b0, bus.i_a} + {1'b0, bus.i_b};
    assign w_diff = {1'b0, bus.i_a} - {1'b0, bus.i_b};

`ifdef SEQUENTIAL_ALU_MUL_EN
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_is_mul;
    logic               w_mul_last;

    assign w_is_mul   = (bus.i_instruction == OP_MUL);
    assign w_mul_last = (r_state == S_MUL) && (r_cnt == CNT_W'(WIDTH - 1));
    // Full-width accumulator so the carry flag can see every high product bit.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Shift-add multiplier: load operands on accept, then one bit per MUL cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_accept && w_is_mul) begin
            r_mcand  <= {{WIDTH{1'b0}}, bus.i_a};
            r_mplier <= bus.i_b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_MUL) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_acc_next;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end
`endif

    // Single-cycle datapath; opcode 110 lands in the illegal branch, which is
    // the required behaviour without a multiplier and is never loaded with one.
    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        w_alu_ovf   = 1'b0;
        w_alu_err   = 1'b0;
        case (bus.i_instruction)
            OP_OR:   w_alu_res = bus.i_a | bus.i_b;
            OP_NAND: w_alu_res = ~(bus.i_a & bus.i_b);
            OP_NOR:  w_alu_res = ~(bus.i_a | bus.i_b);
            OP_AND:  w_alu_res = bus.i_a & bus.i_b;
            OP_ADD: begin
                w_alu_res   = w_sum[WIDTH-1:0];
                w_alu_carry = w_sum[WIDTH];
                w_alu_ovf   = (bus.i_a[WIDTH-1] == bus.i_b[WIDTH-1]) &&
                              (w_sum[WIDTH-1] != bus.i_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res   = w_diff[WIDTH-1:0];
                w_alu_carry = w_diff[WIDTH];
                w_alu_ovf   = (bus.i_a[WIDTH-1] != bus.i_b[WIDTH-1]) &&
                              (w_diff[WIDTH-1] != bus.i_a[WIDTH-1]);
            end
            default: w_alu_err = 1'b1;
        endcase
    end

    // Pick what gets written into the result registers this cycle, if anything.
    always_comb begin
        w_load       = w_accept;
        w_load_out   = w_alu_res;
        w_load_carry = w_alu_carry;
        w_load_zero  = (w_alu_res == '0) && !w_alu_err;
        w_load_ovf   = w_alu_ovf;
        w_load_err   = w_alu_err;
`ifdef SEQUENTIAL_ALU_MUL_EN
        if (w_accept && w_is_mul) begin
            w_load = 1'b0;
        end
        if (w_mul_last) begin
            w_load       = 1'b1;
            w_load_out   = w_acc_next[WIDTH-1:0];
            w_load_carry = |w_acc_next[2*WIDTH-1:WIDTH];
            w_load_zero  = (w_acc_next[WIDTH-1:0] == '0);
            w_load_ovf   = 1'b0;
            w_load_err   = 1'b0;
        end
`endif
    end

    // Result and flag registers: written once per operation, held through DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out      <= '0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_load) begin
            r_out      <= w_load_out;
            r_carry    <= w_load_carry;
            r_zero     <= w_load_zero;
            r_overflow <= w_load_ovf;
            r_err      <= w_load_err;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: IDLE -> (MUL ->) DONE -> IDLE on consumer handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.i_valid) begin
`ifdef SEQUENTIAL_ALU_MUL_EN
                    w_state_next = w_is_mul ? S_MUL : S_DONE;
`else
                    w_state_next = S_DONE;
`endif
                end
            end
`ifdef SEQUENTIAL_ALU_MUL_EN
            S_MUL: begin
                if (w_mul_last) begin
                    w_state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (bus.i_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.o_ready    = (r_state == S_IDLE);
    assign bus.o_valid    = (r_state == S_DONE);
    assign bus.out        = r_out;
    assign bus.o_carry    = r_carry;
    assign bus.o_zero     = r_zero;
    assign bus.o_overflow = r_overflow;
    assign bus.o_err      = r_err;
endmodule
